clock_mode_controller: RTL and testbench

- Central control FSM for the digital clock/alarm. It consumes the one-cycle pulses produced by the five push-button detectors and sequences the clock-adjust, alarm-adjust and alarm-ringing modes.
- Drives inc/dec strobes and a hold signal to the timekeeping counters, owns the alarm hour/minute registers, and detects the alarm match.
- Sits between the button detectors and the timekeeping/display blocks.

---
 rtl/clock_pkg.sv | 55 +++++
 rtl/mod_adjust_counter.sv | 36 +++
 rtl/clock_mode_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_clock_mode_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and field-navigation helpers for the clock/alarm mode controller.
package clock_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int HOURS   = 24;
  localparam int MINUTES = 60;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_ADJ_C_HR  = 3'd1,
    ST_ADJ_C_MIN = 3'd2,
    ST_ADJ_A_HR  = 3'd3,
    ST_ADJ_A_MIN = 3'd4,
    ST_RING      = 3'd5
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;

  function automatic logic is_adjust(input state_t s);
    is_adjust = (s == ST_ADJ_C_HR) || (s == ST_ADJ_C_MIN) ||
                (s == ST_ADJ_A_HR) || (s == ST_ADJ_A_MIN);
  endfunction

  function automatic state_t field_next(input state_t s);
    case (s)
      ST_ADJ_C_HR:  field_next = ST_ADJ_C_MIN;
      ST_ADJ_C_MIN: field_next = ST_ADJ_A_HR;
      ST_ADJ_A_HR:  field_next = ST_ADJ_A_MIN;
      ST_ADJ_A_MIN: field_next = ST_ADJ_C_HR;
      default:      field_next = ST_RUN;
    endcase
  endfunction

  function automatic state_t field_prev(input state_t s);
    case (s)
      ST_ADJ_C_HR:  field_prev = ST_ADJ_A_MIN;
      ST_ADJ_C_MIN: field_prev = ST_ADJ_C_HR;
      ST_ADJ_A_HR:  field_prev = ST_ADJ_C_MIN;
      ST_ADJ_A_MIN: field_prev = ST_ADJ_A_HR;
      default:      field_prev = ST_RUN;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      ST_ADJ_C_HR,  ST_ADJ_A_HR:  sel_of = SEL_HOUR;
      ST_ADJ_C_MIN, ST_ADJ_A_MIN: sel_of = SEL_MIN;
      default:                    sel_of = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mod_adjust_counter.sv
// Wrap-around up/down register holding one alarm field (value in 0..MOD-1).
module mod_adjust_counter #(
  parameter int MOD     = 24,
  parameter int W       = 5,
  parameter int RST_VAL = 0
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);
  localparam logic [W-1:0] RST_V   = W'(RST_VAL);
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] ZERO    = W'(0);

  logic [W-1:0] r_value;

  assign value = r_value;

  // inc takes precedence; the controller never raises both together
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_value <= RST_V;
    end else if (inc) begin
      r_value <= (r_value == MAX_VAL) ? ZERO : r_value + ONE;
    end else if (dec) begin
      r_value <= (r_value == ZERO) ? MAX_VAL : r_value - ONE;
    end else begin
      r_value <= r_value;
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// Clock/alarm mode FSM: button arbitration, adjust strobes, alarm registers and ringing.
// Optional inactivity auto-exit from adjust states is enabled by defining ADJ_TIMEOUT_EN.
module clock_mode_controller
  import clock_pkg::*;
#(
  parameter int RING_SEC       = 60,
  parameter int ALARM_RST_HOUR = 6,
  parameter int ALARM_RST_MIN  = 0,
  parameter int TIMEOUT_SEC    = 15
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              btn_c,
  input  logic              btn_u,
  input  logic              btn_d,
  input  logic              btn_l,
  input  logic              btn_r,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [MIN_W-1:0]  cur_sec,
  output logic              clk_inc_hour,
  output logic              clk_dec_hour,
  output logic              clk_inc_min,
  output logic              clk_dec_min,
  output logic              clk_hold,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic [MIN_W-1:0]  alarm_min,
  output logic              alarm_armed,
  output logic              alarm_ring,
  output logic [2:0]        mode,
  output logic [1:0]        sel_field
);

  localparam logic [7:0] RING_LIM    = 8'(RING_SEC);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_SEC);

  state_t     r_state;
  logic       r_inc_hr, r_dec_hr, r_inc_min, r_dec_min;
  logic       r_hold, r_ring, r_armed, r_match;
  logic [1:0] r_sel;
  logic [7:0] r_ring_cnt;

  state_t w_nxt;
  logic   w_c, w_r, w_l, w_u, w_d, w_any;
  logic   w_match_now, w_match_edge, w_timeout, w_act, w_arm_tgl;
  logic   w_inc_hr, w_dec_hr, w_inc_min, w_dec_min;
  logic   w_ahr_inc, w_ahr_dec, w_amin_inc, w_amin_dec;

  // One-hot arbitration: C > R > L > U > D, losers are simply dropped
  assign w_c   = btn_c;
  assign w_r   = ~btn_c & btn_r;
  assign w_l   = ~btn_c & ~btn_r & btn_l;
  assign w_u   = ~btn_c & ~btn_r & ~btn_l & btn_u;
  assign w_d   = ~btn_c & ~btn_r & ~btn_l & ~btn_u & btn_d;
  assign w_any = btn_c | btn_r | btn_l | btn_u | btn_d;

  assign w_match_now  = r_armed & (cur_hour == alarm_hour) & (cur_min == alarm_min) &
                        (cur_sec == 6'd0);
  assign w_match_edge = w_match_now & ~r_match;

  always_comb begin
    w_nxt      = r_state;
    w_act      = 1'b0;
    w_arm_tgl  = 1'b0;
    w_inc_hr   = 1'b0;
    w_dec_hr   = 1'b0;
    w_inc_min  = 1'b0;
    w_dec_min  = 1'b0;
    w_ahr_inc  = 1'b0;
    w_ahr_dec  = 1'b0;
    w_amin_inc = 1'b0;
    w_amin_dec = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_match_edge) begin
          w_nxt = ST_RING;
        end else if (w_c) begin
          w_nxt = ST_ADJ_C_HR;
          w_act = 1'b1;
        end else if (w_u) begin
          w_arm_tgl = 1'b1;
          w_act     = 1'b1;
        end else begin
          w_nxt = ST_RUN;
        end
      end
      ST_ADJ_C_HR, ST_ADJ_C_MIN, ST_ADJ_A_HR, ST_ADJ_A_MIN: begin
        if (w_timeout) begin
          w_nxt = ST_RUN;
        end else if (w_c) begin
          w_nxt = ST_RUN;
          w_act = 1'b1;
        end else if (w_r) begin
          w_nxt = field_next(r_state);
          w_act = 1'b1;
        end else if (w_l) begin
          w_nxt = field_prev(r_state);
          w_act = 1'b1;
        end else if (w_u || w_d) begin
          w_act      = 1'b1;
          w_inc_hr   = w_u & (r_state == ST_ADJ_C_HR);
          w_dec_hr   = w_d & (r_state == ST_ADJ_C_HR);
          w_inc_min  = w_u & (r_state == ST_ADJ_C_MIN);
          w_dec_min  = w_d & (r_state == ST_ADJ_C_MIN);
          w_ahr_inc  = w_u & (r_state == ST_ADJ_A_HR);
          w_ahr_dec  = w_d & (r_state == ST_ADJ_A_HR);
          w_amin_inc = w_u & (r_state == ST_ADJ_A_MIN);
          w_amin_dec = w_d & (r_state == ST_ADJ_A_MIN);
        end else begin
          w_nxt = r_state;
        end
      end
      ST_RING: begin
        if (w_any) begin
          w_nxt = ST_RUN;
          w_act = 1'b1;
        end else if (tick_1hz && ((r_ring_cnt + 8'd1) == RING_LIM)) begin
          w_nxt = ST_RUN;
        end else begin
          w_nxt = ST_RING;
        end
      end
      default: begin
        w_nxt = ST_RUN;
      end
    endcase
  end

  // State, strobes and mode-derived outputs are all registered from the next state
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_inc_hr   <= 1'b0;
      r_dec_hr   <= 1'b0;
      r_inc_min  <= 1'b0;
      r_dec_min  <= 1'b0;
      r_hold     <= 1'b0;
      r_ring     <= 1'b0;
      r_armed    <= 1'b0;
      r_match    <= 1'b0;
      r_sel      <= SEL_NONE;
      r_ring_cnt <= 8'd0;
    end else begin
      r_state   <= w_nxt;
      r_inc_hr  <= w_inc_hr;
      r_dec_hr  <= w_dec_hr;
      r_inc_min <= w_inc_min;
      r_dec_min <= w_dec_min;
      r_hold    <= (w_nxt == ST_ADJ_C_HR) || (w_nxt == ST_ADJ_C_MIN);
      r_ring    <= (w_nxt == ST_RING);
      r_armed   <= r_armed ^ w_arm_tgl;
      r_match   <= w_match_now;
      r_sel     <= sel_of(w_nxt);
      if (r_state != ST_RING) begin
        r_ring_cnt <= 8'd0;
      end else if (tick_1hz) begin
        r_ring_cnt <= r_ring_cnt + 8'd1;
      end else begin
        r_ring_cnt <= r_ring_cnt;
      end
    end
  end

`ifdef ADJ_TIMEOUT_EN
  logic [7:0] r_idle;

  assign w_timeout = is_adjust(r_state) && (r_idle == TIMEOUT_LIM);

  // Idle seconds in adjust; held at zero outside adjust so every entry starts fresh
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_idle <= 8'd0;
    end else if (!is_adjust(r_state) || w_act) begin
      r_idle <= 8'd0;
    end else if (tick_1hz) begin
      r_idle <= r_idle + 8'd1;
    end else begin
      r_idle <= r_idle;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^{TIMEOUT_LIM, w_act};
`endif

  mod_adjust_counter #(
    .MOD     (HOURS),
    .W       (HOUR_W),
    .RST_VAL (ALARM_RST_HOUR)
  ) u_alarm_hour (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (w_ahr_inc),
    .dec    (w_ahr_dec),
    .value  (alarm_hour)
  );

  mod_adjust_counter #(
    .MOD     (MINUTES),
    .W       (MIN_W),
    .RST_VAL (ALARM_RST_MIN)
  ) u_alarm_min (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (w_amin_inc),
    .dec    (w_amin_dec),
    .value  (alarm_min)
  );

  assign clk_inc_hour = r_inc_hr;
  assign clk_dec_hour = r_dec_hr;
  assign clk_inc_min  = r_inc_min;
  assign clk_dec_min  = r_dec_min;
  assign clk_hold     = r_hold;
  assign alarm_armed  = r_armed;
  assign alarm_ring   = r_ring;
  assign mode         = r_state;
  assign sel_field    = r_sel;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed self-checking bench for clock_mode_controller; honours ADJ_TIMEOUT_EN for the idle-exit step.
module tb_clock_mode_controller;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BR = 5'b01000;
  localparam logic [4:0] BL = 5'b00100;
  localparam logic [4:0] BU = 5'b00010;
  localparam logic [4:0] BD = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       b_c, b_r, b_l, b_u, b_d;
  logic [4:0] hr;
  logic [5:0] mn, sc;
  logic       inc_h, dec_h, inc_m, dec_m, hold, armed, ring;
  logic [4:0] a_hr;
  logic [5:0] a_mn;
  logic [2:0] mode;
  logic [1:0] sel;
  logic [3:0] st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign st = {inc_h, dec_h, inc_m, dec_m};

  clock_mode_controller #(
    .RING_SEC       (60),
    .ALARM_RST_HOUR (6),
    .ALARM_RST_MIN  (0),
    .TIMEOUT_SEC    (3)
  ) dut (
    .clk_in       (clk),
    .rst          (rst_n),
    .tick_1hz     (tick),
    .btn_c        (b_c),
    .btn_u        (b_u),
    .btn_d        (b_d),
    .btn_l        (b_l),
    .btn_r        (b_r),
    .cur_hour     (hr),
    .cur_min      (mn),
    .cur_sec      (sc),
    .clk_inc_hour (inc_h),
    .clk_dec_hour (dec_h),
    .clk_inc_min  (inc_m),
    .clk_dec_min  (dec_m),
    .clk_hold     (hold),
    .alarm_hour   (a_hr),
    .alarm_min    (a_mn),
    .alarm_armed  (armed),
    .alarm_ring   (ring),
    .mode         (mode),
    .sel_field    (sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    {b_c, b_r, b_l, b_u, b_d} = b;
    cyc();
    {b_c, b_r, b_l, b_u, b_d} = 5'd0;
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    {b_c, b_r, b_l, b_u, b_d} = 5'd0;
    hr = 5'd12; mn = 6'd34; sc = 6'd56;
    repeat (2) cyc();
    chk("rst_mode", mode, 0);
    chk("rst_ahr", a_hr, 6);
    chk("rst_amin", a_mn, 0);
    chk("rst_strobes", st, 0);
    chk("rst_hold", hold, 0);
    chk("rst_ring", ring, 0);
    chk("rst_armed", armed, 0);
    chk("rst_sel", sel, 0);
    rst_n = 1'b1;
    cyc();
    chk("rel_strobes", st, 0);

    // reset asserted mid ADJ_A_MIN with a button pending
    press(BC);
    press(BL);
    chk("enter_amin", mode, 4);
    press(BU);
    chk("amin_inc", a_mn, 1);
    {b_c, b_r, b_l, b_u, b_d} = BU;
    rst_n = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_amin", a_mn, 0);
    cyc();
    chk("arst_hold_amin", a_mn, 0);
    chk("arst_strobes", st, 0);
    {b_c, b_r, b_l, b_u, b_d} = 5'd0;
    rst_n = 1'b1;
    cyc();
    chk("arel_strobes", st, 0);
    chk("arel_mode", mode, 0);

    // clock adjust strobes
    press(BC);
    chk("cadj_mode", mode, 1);
    chk("cadj_sel", sel, 1);
    chk("cadj_hold", hold, 1);
    press(BU);
    chk("inc_hour", st, 4'b1000);
    cyc();
    chk("inc_hour_1cyc", st, 0);
    press(BD);
    chk("dec_hour", st, 4'b0100);
    press(BR);
    chk("cmin_mode", mode, 2);
    chk("cmin_sel", sel, 2);
    chk("cmin_strobes", st, 0);
    press(BU);
    chk("inc_min", st, 4'b0010);
    press(BD);
    chk("dec_min", st, 4'b0001);
    press(BC | BU);
    chk("cu_mode", mode, 0);
    chk("cu_strobes", st, 0);
    chk("cu_hold", hold, 0);
    chk("cu_sel", sel, 0);
    press(BR | BU);
    chk("ru_armed", armed, 0);
    chk("ru_mode", mode, 0);

    // alarm register wrap
    press(BC);
    press(BL);
    chk("amin_mode", mode, 4);
    chk("amin_hold", hold, 0);
    press(BD);
    chk("amin_wrap_dn", a_mn, 59);
    press(BU);
    chk("amin_wrap_up", a_mn, 0);
    press(BL);
    chk("ahr_mode", mode, 3);
    chk("ahr_sel", sel, 1);
    repeat (6) press(BD);
    chk("ahr_zero", a_hr, 0);
    press(BD);
    chk("ahr_wrap_dn", a_hr, 23);
    chk("ahr_no_strobe", st, 0);
    press(BU);
    chk("ahr_wrap_up", a_hr, 0);
    repeat (6) press(BU);
    chk("ahr_back", a_hr, 6);
    press(BR);
    chk("r_3to4", mode, 4);
    press(BR);
    chk("r_4to1", mode, 1);
    press(BC);
    chk("back_run", mode, 0);

    // alarm ring with auto-silence
    press(BU);
    chk("armed_on", armed, 1);
    hr = 5'd6; mn = 6'd0; sc = 6'd0;
    cyc();
    chk("ring_mode", mode, 5);
    chk("ring_out", ring, 1);
    sc = 6'd1;
    repeat (59) tk();
    chk("ring_59", mode, 5);
    tk();
    chk("ring_60_mode", mode, 0);
    chk("ring_60_out", ring, 0);
    chk("ring_60_armed", armed, 1);

    // match beats a coincident button, then a button silences
    sc = 6'd0;
    press(BC);
    chk("match_wins", mode, 5);
    sc = 6'd1;
    repeat (3) tk();
    press(BD);
    chk("btn_sil_mode", mode, 0);
    chk("btn_sil_ring", ring, 0);
    chk("btn_sil_armed", armed, 1);
    chk("btn_sil_amin", a_mn, 0);
    chk("btn_sil_strobes", st, 0);

    // match during adjust is lost
    press(BC);
    sc = 6'd0;
    cyc();
    chk("adj_match_mode", mode, 1);
    sc = 6'd1;
    cyc();
    press(BC);
    cyc();
    chk("lost_match", mode, 0);

    // idle timeout from ADJ_A_HR
    hr = 5'd12; mn = 6'd34; sc = 6'd56;
    press(BC);
    press(BL);
    press(BL);
    chk("to_enter", mode, 3);
    tk();
    tk();
    press(BU);
    chk("to_ahr", a_hr, 7);
    tk();
    tk();
    chk("to_pre", mode, 3);
    tk();
    cyc();
    cyc();
`ifdef ADJ_TIMEOUT_EN
    chk("to_mode", mode, 0);
`else
    chk("to_mode", mode, 3);
`endif
    chk("to_ahr_kept", a_hr, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
